// File: rtl/lc3_intc_pkg.sv
// Shared types and helpers for the LC-3 external interrupt controller.
// Imported by the controller top and its arbiter.
package lc3_intc_pkg;

    localparam int DEF_PRI_W = 3;
    localparam int DEF_VEC_W = 8;

    typedef enum logic [0:0] {
        IDLE,
        ASSERT
    } state_e;

    // Callers truncate the result to their vector width, which gives the modulo wrap.
    function automatic logic [31:0] vec_of(input logic [31:0] base, input logic [31:0] idx);
        return base + idx;
    endfunction

endpackage

// File: rtl/lc3_intc_arb.sv
// Combinational arbiter: picks the highest-priority eligible source.
// Ties resolve to the lowest source index.
module lc3_intc_arb #(
    parameter int NUM_SRC = 8,
    parameter int PRI_W   = 3,
    parameter int SEL_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic [NUM_SRC-1:0]            i_eligible,
    input  logic [NUM_SRC-1:0][PRI_W-1:0] i_pri,
    output logic                          o_valid,
    output logic [SEL_W-1:0]              o_winner
);

    logic [PRI_W-1:0] w_best_pri;

    always_comb begin
        o_valid    = 1'b0;
        o_winner   = '0;
        w_best_pri = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            // Strict compare while scanning upward keeps the lowest index on ties.
            if (i_eligible[i] && (!o_valid || (i_pri[i] > w_best_pri))) begin
                o_valid    = 1'b1;
                o_winner   = SEL_W'(i);
                w_best_pri = i_pri[i];
            end
        end
    end

endmodule

// File: rtl/lc3_intc.sv
// External interrupt controller driving the LC-3 IRQ/INTV/INTP inputs.
// Per-source enable/priority registers, edge or level sensing, arbitration and ack handshake.
module lc3_intc
    import lc3_intc_pkg::*;
#(
    parameter int                 NUM_SRC   = 8,
    parameter int                 PRI_W     = DEF_PRI_W,
    parameter int                 VEC_W     = DEF_VEC_W,
    parameter logic [VEC_W-1:0]   VEC_BASE  = VEC_W'('h80),
    parameter logic [NUM_SRC-1:0] EDGE_MASK = '1,
    localparam int                SEL_W     = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] src_irq,
    input  logic               cfg_we,
    input  logic [SEL_W-1:0]   cfg_sel,
    input  logic               cfg_en,
    input  logic [PRI_W-1:0]   cfg_pri,
    input  logic [PRI_W-1:0]   cpu_pri,
    input  logic               int_ack,
    output logic               IRQ,
    output logic [VEC_W-1:0]   INTV,
    output logic [PRI_W-1:0]   INTP,
    output logic [NUM_SRC-1:0] pending
);

    logic [NUM_SRC-1:0]            r_src_q;
    logic [NUM_SRC-1:0]            r_pending;
    logic [NUM_SRC-1:0]            r_en;
    logic [NUM_SRC-1:0][PRI_W-1:0] r_pri;
    state_e                        r_state;
    logic [SEL_W-1:0]              r_win;
    logic                          r_irq;
    logic [VEC_W-1:0]              r_intv;
    logic [PRI_W-1:0]              r_intp;

    logic [NUM_SRC-1:0] w_rise;
    logic [NUM_SRC-1:0] w_clr;
    logic [NUM_SRC-1:0] w_pending_d;
    logic [NUM_SRC-1:0] w_eligible;
    logic               w_valid;
    logic [SEL_W-1:0]   w_winner;
    logic [VEC_W-1:0]   w_vec;
    logic               w_win_elig;
    logic               w_retarget;
    logic               w_cfg_hit;

    assign w_rise    = src_irq & ~r_src_q;
    assign w_cfg_hit = cfg_we && (32'(cfg_sel) < 32'(NUM_SRC));

    // Only the presented winner is cleared, and only by an ack while it is presented.
    always_comb begin
        w_clr = '0;
        if ((r_state == ASSERT) && int_ack) begin
            w_clr[r_win] = 1'b1;
        end
    end

    always_comb begin
        w_pending_d = '0;
        w_eligible  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (EDGE_MASK[i]) begin
                // A fresh rise beats a simultaneous ack so the new event is not lost.
                w_pending_d[i] = w_rise[i] | (r_pending[i] & ~w_clr[i]);
            end else begin
                w_pending_d[i] = src_irq[i];
            end
            w_eligible[i] = r_pending[i] & r_en[i] & (r_pri[i] > cpu_pri);
        end
    end

    lc3_intc_arb #(
        .NUM_SRC (NUM_SRC),
        .PRI_W   (PRI_W),
        .SEL_W   (SEL_W)
    ) u_arb (
        .i_eligible (w_eligible),
        .i_pri      (r_pri),
        .o_valid    (w_valid),
        .o_winner   (w_winner)
    );

    assign w_vec      = VEC_W'(vec_of(32'(VEC_BASE), 32'(w_winner)));
    assign w_win_elig = w_eligible[r_win];
    assign w_retarget = w_valid && (!w_win_elig || (r_pri[w_winner] > r_pri[r_win]));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_src_q   <= '0;
            r_pending <= '0;
        end else begin
            r_src_q   <= src_irq;
            r_pending <= w_pending_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_en  <= '0;
            r_pri <= '0;
        end else if (w_cfg_hit) begin
            r_en[cfg_sel]  <= cfg_en;
            r_pri[cfg_sel] <= cfg_pri;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_irq   <= 1'b0;
            r_win   <= '0;
            r_intv  <= '0;
            r_intp  <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_valid) begin
                        r_win   <= w_winner;
                        r_intv  <= w_vec;
                        r_intp  <= r_pri[w_winner];
                        r_irq   <= 1'b1;
                        r_state <= ASSERT;
                    end
                end
                ASSERT: begin
                    if (int_ack) begin
                        r_irq   <= 1'b0;
                        r_state <= IDLE;
                    end else if (w_retarget) begin
                        r_win  <= w_winner;
                        r_intv <= w_vec;
                        r_intp <= r_pri[w_winner];
                    end else if (!w_win_elig) begin
                        r_irq   <= 1'b0;
                        r_state <= IDLE;
                    end
                end
            endcase
        end
    end

    assign IRQ     = r_irq;
    assign INTV    = r_intv;
    assign INTP    = r_intp;
    assign pending = r_pending;

endmodule

// File: tb/tb_lc3_intc.sv
// Self-checking bench for lc3_intc: directed scenarios then random traffic,
// every cycle compared against a behavioural model of the controller.
module tb_lc3_intc;

    localparam logic [7:0] TB_EDGE = 8'hBF;

    logic       clk;
    logic       rst;
    logic [7:0] src_irq;
    logic       cfg_we;
    logic [2:0] cfg_sel;
    logic       cfg_en;
    logic [2:0] cfg_pri;
    logic [2:0] cpu_pri;
    logic       int_ack;
    logic       IRQ;
    logic [7:0] INTV;
    logic [2:0] INTP;
    logic [7:0] pending;

    lc3_intc #(
        .NUM_SRC   (8),
        .PRI_W     (3),
        .VEC_W     (8),
        .VEC_BASE  (8'h80),
        .EDGE_MASK (TB_EDGE)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .src_irq (src_irq),
        .cfg_we  (cfg_we),
        .cfg_sel (cfg_sel),
        .cfg_en  (cfg_en),
        .cfg_pri (cfg_pri),
        .cpu_pri (cpu_pri),
        .int_ack (int_ack),
        .IRQ     (IRQ),
        .INTV    (INTV),
        .INTP    (INTP),
        .pending (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state
    bit [7:0] m_pend;
    bit [7:0] m_srcq;
    bit       m_en [8];
    int       m_pri [8];
    bit       m_irq;
    int       m_win;
    bit [7:0] m_intv;
    bit [2:0] m_intp;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    endtask

    task automatic model_reset();
        m_pend = '0;
        m_srcq = '0;
        m_irq  = 1'b0;
        m_win  = 0;
        m_intv = '0;
        m_intp = '0;
        for (int i = 0; i < 8; i++) begin
            m_en[i]  = 1'b0;
            m_pri[i] = 0;
        end
    endtask

    task automatic present(input int b);
        m_win  = b;
        m_intv = 8'((128 + b) % 256);
        m_intp = 3'(m_pri[b]);
        m_irq  = 1'b1;
    endtask

    // Next state from the current model state and the inputs about to be sampled.
    task automatic model_next();
        bit [7:0] np;
        bit [7:0] elig;
        int       top;
        int       best;
        top  = -1;
        best = -1;
        for (int i = 0; i < 8; i++) begin
            elig[i] = m_pend[i] && m_en[i] && (m_pri[i] > int'(cpu_pri));
            if (elig[i] && m_pri[i] > top) top = m_pri[i];
        end
        for (int i = 7; i >= 0; i--) begin
            if (elig[i] && m_pri[i] == top) best = i;
        end
        for (int i = 0; i < 8; i++) begin
            if (TB_EDGE[i])
                np[i] = (src_irq[i] && !m_srcq[i]) ||
                        (m_pend[i] && !(m_irq && int_ack && m_win == i));
            else
                np[i] = src_irq[i];
        end
        if (!m_irq) begin
            if (best >= 0) present(best);
        end else if (int_ack) begin
            m_irq = 1'b0;
        end else if (!elig[m_win]) begin
            if (best >= 0) present(best);
            else m_irq = 1'b0;
        end else if (best >= 0 && m_pri[best] > m_pri[m_win]) begin
            present(best);
        end
        if (cfg_we && int'(cfg_sel) < 8) begin
            m_en[cfg_sel]  = cfg_en;
            m_pri[cfg_sel] = int'(cfg_pri);
        end
        m_pend = np;
        m_srcq = src_irq;
    endtask

    task automatic tick();
        model_next();
        @(posedge clk);
        #1;
        check("IRQ", 32'(IRQ), 32'(m_irq));
        check("INTV", 32'(INTV), 32'(m_intv));
        check("INTP", 32'(INTP), 32'(m_intp));
        check("pending", 32'(pending), 32'(m_pend));
    endtask

    task automatic do_cfg(input int s, input bit e, input int p);
        cfg_we  = 1'b1;
        cfg_sel = 3'(s);
        cfg_en  = e;
        cfg_pri = 3'(p);
        tick();
        cfg_we  = 1'b0;
    endtask

    task automatic pulse(input logic [7:0] m);
        src_irq = m;
        tick();
        src_irq = '0;
    endtask

    task automatic ack();
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
    endtask

    initial begin
        rst     = 1'b1;
        src_irq = '0;
        cfg_we  = 1'b0;
        cfg_sel = '0;
        cfg_en  = 1'b0;
        cfg_pri = '0;
        cpu_pri = '0;
        int_ack = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst IRQ", 32'(IRQ), 0);
        check("rst INTV", 32'(INTV), 0);
        check("rst INTP", 32'(INTP), 0);
        check("rst pending", 32'(pending), 0);
        @(negedge clk);
        rst = 1'b0;

        // Single edge pulse: two-cycle latency, ack clears
        do_cfg(2, 1'b1, 4);
        pulse(8'h04);
        check("t1 pending", 32'(pending), 32'h04);
        check("t1 irq early", 32'(IRQ), 0);
        tick();
        check("t1 IRQ", 32'(IRQ), 1);
        check("t1 INTV", 32'(INTV), 32'h82);
        check("t1 INTP", 32'(INTP), 4);
        ack();
        check("t1 ack IRQ", 32'(IRQ), 0);
        check("t1 ack pending", 32'(pending), 0);

        // Equal priorities: lowest index first, one idle cycle between
        do_cfg(1, 1'b1, 5);
        do_cfg(3, 1'b1, 5);
        pulse(8'h0A);
        tick();
        check("t2 first", 32'(INTV), 32'h81);
        ack();
        check("t2 idle", 32'(IRQ), 0);
        tick();
        check("t2 second IRQ", 32'(IRQ), 1);
        check("t2 second", 32'(INTV), 32'h83);
        ack();

        // Preemption by a higher-priority source before ack
        do_cfg(0, 1'b1, 3);
        do_cfg(5, 1'b1, 6);
        pulse(8'h01);
        tick();
        check("t3 src0", 32'(INTV), 32'h80);
        pulse(8'h20);
        tick();
        check("t3 retarget", 32'(INTV), 32'h85);
        check("t3 held", 32'(IRQ), 1);
        check("t3 INTP", 32'(INTP), 6);
        ack();
        tick();
        check("t3 back", 32'(INTV), 32'h80);
        ack();

        // CPU priority masking
        cpu_pri = 3'd4;
        do_cfg(4, 1'b1, 4);
        pulse(8'h10);
        tick();
        tick();
        check("t4 masked", 32'(IRQ), 0);
        cpu_pri = 3'd3;
        tick();
        check("t4 unmasked", 32'(IRQ), 1);
        check("t4 INTV", 32'(INTV), 32'h84);
        ack();
        cpu_pri = 3'd0;

        // Level source: re-asserts after ack, withdraws when line drops
        do_cfg(6, 1'b1, 2);
        src_irq = 8'h40;
        tick();
        tick();
        check("t5 IRQ", 32'(INTV), 32'h86);
        ack();
        check("t5 idle", 32'(IRQ), 0);
        tick();
        check("t5 reassert", 32'(IRQ), 1);
        src_irq = '0;
        tick();
        tick();
        check("t5 withdraw", 32'(IRQ), 0);

        // Asynchronous reset while asserting
        pulse(8'h04);
        tick();
        check("t6 pre", 32'(IRQ), 1);
        rst = 1'b1;
        #1;
        model_reset();
        check("t6 IRQ", 32'(IRQ), 0);
        check("t6 pending", 32'(pending), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        pulse(8'h04);
        tick();
        tick();
        check("t6 no irq", 32'(IRQ), 0);

        // Random traffic
        for (int i = 0; i < 8; i++) do_cfg(i, 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)));
        for (int c = 0; c < 800; c++) begin
            src_irq = 8'($urandom & $urandom);
            int_ack = ($urandom_range(0, 3) == 0);
            cfg_we  = ($urandom_range(0, 7) == 0);
            cfg_sel = 3'($urandom_range(0, 7));
            cfg_en  = ($urandom_range(0, 3) != 0);
            cfg_pri = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 15) == 0) cpu_pri = 3'($urandom_range(0, 5));
            tick();
        end
        int_ack = 1'b0;
        cfg_we  = 1'b0;
        src_irq = '0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
